// File: rtl/alu_bist_pipe.sv
// Registered WIDTH-bit ALU with carry/zero flags and a built-in self-test engine:
// a 32-bit Galois LFSR supplies operands/opcodes and a WIDTH-bit MISR compacts results.
module alu_bist_pipe #(
    parameter int          WIDTH      = 8,
    parameter int          PATTERNS   = 255,
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       CMD,
    input  logic             IN_VALID,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             ZERO,
    output logic             OUT_VALID,
    input  logic             BIST_START,
    output logic             BIST_BUSY,
    output logic             BIST_DONE,
    output logic             BIST_PASS,
    output logic [WIDTH-1:0] SIGNATURE
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LFSR_TAP = 32'h8020_0003;
    localparam logic [15:0] LAST_PAT = 16'(PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Result layout: {carry/borrow/shift-out, WIDTH-bit result}
    function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0]       cmd);
        logic [WIDTH:0] r;
        case (cmd)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} - {1'b0, b};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
            3'b110:  r = {a[0], 1'b0, a[WIDTH-1:1]};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    state_t           state_q;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [15:0]      cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, zero_q, out_vld_q;
    logic             busy_q, done_q, pass_q;
    logic [WIDTH:0]   func_r, bist_r;

    always_comb begin
        func_r = alu_f(A, B, CMD);
        bist_r = alu_f(lfsr_q[WIDTH-1:0], lfsr_q[2*WIDTH-1:WIDTH], lfsr_q[31:29]);
        misr_d = {misr_q[WIDTH-2:0], misr_q[WIDTH-1]} ^ bist_r[WIDTH-1:0];
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAP) : (lfsr_q >> 1);
    end

    // Register stage: functional result capture and BIST sequencing
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            misr_q    <= '0;
            cnt_q     <= '0;
            s_q       <= '0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            out_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (BIST_START) begin
                        state_q <= RUN;
                        lfsr_q  <= SEED_EFF;
                        misr_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (IN_VALID) begin
                        s_q       <= func_r[WIDTH-1:0];
                        cout_q    <= func_r[WIDTH];
                        zero_q    <= (func_r[WIDTH-1:0] == '0);
                        out_vld_q <= 1'b1;
                    end
                end
                RUN: begin
                    misr_q <= misr_d;
                    lfsr_q <= lfsr_d;
                    cnt_q  <= cnt_q + 16'd1;
                    if (cnt_q == LAST_PAT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    pass_q  <= (misr_q == GOLDEN_SIG[WIDTH-1:0]);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign S         = s_q;
    assign COUT      = cout_q;
    assign ZERO      = zero_q;
    assign OUT_VALID = out_vld_q;
    assign BIST_BUSY = busy_q;
    assign BIST_DONE = done_q;
    assign BIST_PASS = pass_q;
    assign SIGNATURE = misr_q;

endmodule

// File: tb/tb_alu_bist_pipe.sv
// Scoreboard bench for alu_bist_pipe: one instance with the correct golden signature,
// one with a deliberately wrong one; both share stimulus.
module tb_alu_bist_pipe;

    localparam int W        = 8;
    localparam int PATTERNS = 255;

    function automatic logic [8:0] m_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] c);
        logic [8:0] r;
        r = 9'h0;
        case (c)
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: begin r[7:0] = a - b; r[8] = (a < b); end
            3'd2: r[7:0] = a & b;
            3'd3: r[7:0] = a | b;
            3'd4: r[7:0] = a ^ b;
            3'd5: begin r[7:0] = {a[6:0], 1'b0}; r[8] = a[7]; end
            3'd6: begin r[7:0] = {1'b0, a[7:1]}; r[8] = a[0]; end
            default: r[7:0] = a;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] m_sig(input logic [31:0] seed, input int n);
        logic [31:0] l;
        logic [7:0]  m;
        logic [8:0]  r;
        l = (seed == 32'h0) ? 32'h1 : seed;
        m = 8'h0;
        for (int i = 0; i < n; i++) begin
            r = m_alu(l[7:0], l[15:8], l[31:29]);
            m = {m[6:0], m[7]} ^ r[7:0];
            if (l[0]) l = (l >> 1) ^ 32'h8020_0003;
            else      l = l >> 1;
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD = m_sig(32'h1, PATTERNS);

    logic         clk, rst;
    logic [W-1:0] a, b;
    logic [2:0]   cmd;
    logic         in_valid, bist_start;
    logic [W-1:0] s_p, sig_p, s_f, sig_f;
    logic         cout_p, zero_p, ov_p, busy_p, done_p, pass_p;
    logic         cout_f, zero_f, ov_f, busy_f, done_f, pass_f;

    alu_bist_pipe #(.WIDTH(W), .PATTERNS(PATTERNS), .SEED(32'h1),
                    .GOLDEN_SIG({24'h0, GOLD})) dut_p (
        .CLK(clk), .RST(rst), .A(a), .B(b), .CMD(cmd), .IN_VALID(in_valid),
        .S(s_p), .COUT(cout_p), .ZERO(zero_p), .OUT_VALID(ov_p),
        .BIST_START(bist_start), .BIST_BUSY(busy_p), .BIST_DONE(done_p),
        .BIST_PASS(pass_p), .SIGNATURE(sig_p));

    alu_bist_pipe #(.WIDTH(W), .PATTERNS(PATTERNS), .SEED(32'h1),
                    .GOLDEN_SIG({24'h0, GOLD ^ 8'h01})) dut_f (
        .CLK(clk), .RST(rst), .A(a), .B(b), .CMD(cmd), .IN_VALID(in_valid),
        .S(s_f), .COUT(cout_f), .ZERO(zero_f), .OUT_VALID(ov_f),
        .BIST_START(bist_start), .BIST_BUSY(busy_f), .BIST_DONE(done_f),
        .BIST_PASS(pass_f), .SIGNATURE(sig_f));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [9:0] exp_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Expected entry layout: {zero, cout, s}
    always @(negedge clk) begin
        if (!rst && (ov_p || ov_f)) begin
            if (exp_q.size() == 0) begin
                chk_eq("spurious_out_valid", {ov_p, ov_f}, 2'b00);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk_eq("S", s_p, e[7:0]);
                chk_eq("COUT", cout_p, e[8]);
                chk_eq("ZERO", zero_p, e[9]);
                chk_eq("S_inst2", s_f, e[7:0]);
                chk_eq("OUT_VALID_inst2", ov_f, 1'b1);
            end
        end
    end

    task automatic push_op(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] tc);
        logic [8:0] r;
        a = ta; b = tb; cmd = tc; in_valid = 1'b1;
        r = m_alu(ta, tb, tc);
        exp_q.push_back({(r[7:0] == 8'h0), r});
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] tc);
        @(negedge clk);
        push_op(ta, tb, tc);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Starts a run and returns the number of edges from the start edge to BIST_DONE
    task automatic run_bist(output int dk);
        dk = 0;
        @(negedge clk);
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        chk_eq("busy_after_start", busy_p, 1'b1);
        chk_eq("done_cleared_at_start", {done_p, pass_p, done_f, pass_f}, 4'b0000);
        for (int k = 1; k <= 400 && dk == 0; k++) begin
            @(posedge clk); #1;
            if (k == PATTERNS) chk_eq("busy_last_cycle", busy_p, 1'b1);
            if (k == 50) begin a = 8'h11; b = 8'h22; cmd = 3'd0; in_valid = 1'b1; end
            if (k == 51) begin chk_eq("no_out_valid_in_run", ov_p, 1'b0); in_valid = 1'b0; end
            if (k == 60) bist_start = 1'b1;
            if (k == 61) bist_start = 1'b0;
            if (done_p) begin
                dk = k;
                chk_eq("busy_cleared_at_done", busy_p, 1'b0);
            end
        end
    endtask

    int dk;

    initial begin
        rst = 1'b1; a = '0; b = '0; cmd = '0; in_valid = 1'b0; bist_start = 1'b0;
        #12;
        chk_eq("reset_outputs", {s_p, cout_p, zero_p, ov_p}, 11'h0);
        chk_eq("reset_bist", {busy_p, done_p, pass_p, sig_p}, 11'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'hF0, 8'h20, 3'd0);
        @(negedge clk);
        chk_eq("ov_drops", ov_p, 1'b0);
        chk_eq("S_holds", s_p, 8'h10);

        do_op(8'h05, 8'h05, 3'd1);
        do_op(8'h03, 8'h05, 3'd1);
        do_op(8'h81, 8'h00, 3'd5);
        do_op(8'h81, 8'h00, 3'd6);
        do_op(8'hC3, 8'h5A, 3'd2);
        do_op(8'hC3, 8'h5A, 3'd3);
        do_op(8'hC3, 8'h5A, 3'd4);

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            push_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            @(negedge clk);
        end
        in_valid = 1'b0;

        do_op(8'h5A, 8'hFF, 3'd7);
        repeat (2) @(negedge clk);

        run_bist(dk);
        chk_eq("done_latency", dk, PATTERNS + 1);
        chk_eq("pass_good", {done_p, pass_p}, 2'b11);
        chk_eq("pass_bad_golden", {done_f, pass_f}, 2'b10);
        chk_eq("signature", sig_p, GOLD);
        chk_eq("signature_inst2", sig_f, GOLD);
        chk_eq("S_held_through_run", s_p, 8'h5A);

        repeat (3) @(negedge clk);
        chk_eq("done_sticky", {done_p, pass_p, done_f, pass_f}, 4'b1110);

        // Second run: DONE/PASS clear on the start edge, then reset lands at pattern 100
        @(negedge clk);
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        chk_eq("restart_clears", {done_p, pass_p, done_f, pass_f}, 4'b0000);
        chk_eq("restart_busy", busy_p, 1'b1);
        repeat (99) @(posedge clk);
        #1;
        chk_eq("midrun_busy", busy_p, 1'b1);
        rst = 1'b1;
        #1;
        chk_eq("async_reset_outputs", {s_p, cout_p, zero_p, ov_p}, 11'h0);
        chk_eq("async_reset_bist", {busy_p, done_p, pass_p, sig_p}, 11'h0);
        @(negedge clk);
        rst = 1'b0;

        run_bist(dk);
        chk_eq("done_latency_after_reset", dk, PATTERNS + 1);
        chk_eq("signature_after_reset", sig_p, GOLD);
        chk_eq("pass_after_reset", {pass_p, pass_f}, 2'b10);

        repeat (2) @(negedge clk);
        chk_eq("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
